uart_rx_fifo_engine: RTL and testbench

//  Parametrised UART receiver for the PicoBlaze-style I/O bus: 16x oversampled, majority-voted RX with
//  7/8 data bits and optional even/odd parity. Received words go through an N-deep receive FIFO

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rx_fifo.sv | 40 ++++
 rtl/uart_rx_fifo_engine.sv | 137 +++++++++++++
 tb/tb_uart_rx_fifo_engine.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, baud divisor table and status layout for the UART receive engine.
package uart_pkg;
    localparam int ENTRY_W = 10;
    localparam int ST_RXRDY = 0;
    localparam int ST_PERR = 1;
    localparam int ST_FERR = 2;
    localparam int ST_OVF = 3;
    localparam int ST_FULL = 4;
    localparam int BAUD_RATE [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                                      115200, 230400, 460800, 921600};
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    typedef logic [19:0] baud_div_t;
    typedef baud_div_t [15:0] div_tab_t;
    // Rounded clocks per 16x oversample tick; selects 12..15 alias the fastest rate.
    function automatic div_tab_t div_table(input int clk_hz);
        div_tab_t t;
        for (int i = 0; i < 16; i++) begin
            int r;
            r = BAUD_RATE[i < 12 ? i : 11];
            t[i] = baud_div_t'((clk_hz + r * 8) / (r * 16));
        end
        return t;
    endfunction
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous FIFO with flush; full/empty from wrap-bit pointer compare.
module rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [AW:0] wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic do_push, do_pop;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head = mem[rp[AW-1:0]];
    assign do_pop = pop && !empty;
    // A pop in the same clock frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + ONE;
            if (do_pop) rp <= rp + ONE;
        end
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_rx_fifo_engine.sv
// uart_rx_fifo_engine: 16x oversampled majority-vote UART receiver feeding a tagged receive FIFO,
// with data/status registers on the port_id/read_strobe bus.
module uart_rx_fifo_engine
    import uart_pkg::*;
#(
    parameter int          CLK_HZ      = 100_000_000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DATA_PORT   = 16'h0000,
    parameter logic [15:0] STATUS_PORT = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        eight,
    input  logic        pen,
    input  logic        even,
    input  logic [3:0]  baud,
    input  logic        clr,
    input  logic        read_strobe,
    input  logic [15:0] port_id,
    output logic [7:0]  data,
    output logic [7:0]  status,
    output logic        RXRDY,
    output logic        FERR,
    output logic        PERR,
    output logic        OVF
);
    localparam div_tab_t DIV_TAB = div_table(CLK_HZ);
    state_t state;
    logic rx_s1, rx_s, rx_d, fall, tick, maj, par_x;
    logic eight_q, pen_q, even_q, perr_q, s7, s8, push_q;
    logic [19:0] div_q, div_cnt;
    logic [3:0] tcnt, tn;
    logic [2:0] bcnt;
    logic [7:0] sh, d;
    logic [ENTRY_W-1:0] word_q, head;
    logic full, empty, pop_req, stat_rd;
    assign fall = rx_d && !rx_s;
    assign tick = (state != IDLE) && (div_cnt == div_q - 20'd1);
    assign tn = tcnt + 4'd1;
    assign maj = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign d = eight_q ? sh : {1'b0, sh[7:1]};
    assign par_x = ^d ^ maj;
    assign pop_req = read_strobe && port_id == DATA_PORT;
    assign stat_rd = read_strobe && port_id == STATUS_PORT;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {rx_s1, rx_s, rx_d} <= 3'b111;
        else {rx_s1, rx_s, rx_d} <= {rx, rx_s1, rx_s};
    // Bits are decided on the third of three votes at oversample ticks 7, 8, 9 of each bit.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            div_q <= '0;
            div_cnt <= '0;
            tcnt <= '0;
            bcnt <= '0;
            s7 <= 1'b0;
            s8 <= 1'b0;
            sh <= '0;
            perr_q <= 1'b0;
            eight_q <= 1'b0;
            pen_q <= 1'b0;
            even_q <= 1'b0;
            push_q <= 1'b0;
            word_q <= '0;
        end else if (clr) begin
            state <= IDLE;
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (state == IDLE) begin
                if (fall) begin
                    state <= START;
                    div_q <= DIV_TAB[baud];
                    div_cnt <= '0;
                    tcnt <= '0;
                    bcnt <= '0;
                    perr_q <= 1'b0;
                    eight_q <= eight;
                    pen_q <= pen;
                    even_q <= even;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 20'd1;
                if (tick) begin
                    tcnt <= tn;
                    if (tn == 4'd7) s7 <= rx_s;
                    if (tn == 4'd8) s8 <= rx_s;
                    if (tn == 4'd9)
                        case (state)
                            START: state <= maj ? IDLE : DATA;
                            DATA: begin
                                sh <= {maj, sh[7:1]};
                                bcnt <= bcnt + 3'd1;
                                if (bcnt == {2'b11, eight_q}) state <= pen_q ? PARITY : STOP;
                            end
                            PARITY: begin
                                perr_q <= even_q ? par_x : ~par_x;
                                state <= STOP;
                            end
                            default: begin
                                word_q <= {~maj, perr_q, d};
                                push_q <= 1'b1;
                                state <= IDLE;
                            end
                        endcase
                end
            end
        end
    // An overflow in the same clock as a status read keeps OVF set.
    always_ff @(posedge clk or negedge rst)
        if (!rst) OVF <= 1'b0;
        else OVF <= clr ? 1'b0 : (push_q && full && !pop_req) ? 1'b1 : stat_rd ? 1'b0 : OVF;
    rx_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push_q),
        .pop(pop_req),
        .flush(clr),
        .din(word_q),
        .full(full),
        .empty(empty),
        .head(head)
    );
    assign RXRDY = !empty;
    assign data = empty ? 8'h00 : head[7:0];
    assign FERR = !empty && head[9];
    assign PERR = !empty && head[8];
    always_comb begin
        status = '0;
        status[ST_RXRDY] = RXRDY;
        status[ST_PERR] = PERR;
        status[ST_FERR] = FERR;
        status[ST_OVF] = OVF;
        status[ST_FULL] = full;
    end
endmodule

// File: tb/tb_uart_rx_fifo_engine.sv
// tb_uart_rx_fifo_engine: directed frames at 100 MHz against hand-computed register values.
module tb_uart_rx_fifo_engine;
    localparam int BT = 112;
    localparam int BT8 = 864;
    logic clk = 0, rst = 0, rx = 1, eight = 1, pen = 0, even = 1, clr = 0, read_strobe = 0;
    logic [3:0] baud = 4'd11;
    logic [15:0] port_id = 16'h0000;
    logic [7:0] data, status;
    logic RXRDY, FERR, PERR, OVF;
    int n_checks = 0, n_fail = 0;
    int n;

    uart_rx_fifo_engine #(
        .CLK_HZ(100_000_000),
        .FIFO_DEPTH(4),
        .DATA_PORT(16'h0000),
        .STATUS_PORT(16'h0001)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .eight(eight),
        .pen(pen),
        .even(even),
        .baud(baud),
        .clr(clr),
        .read_strobe(read_strobe),
        .port_id(port_id),
        .data(data),
        .status(status),
        .RXRDY(RXRDY),
        .FERR(FERR),
        .PERR(PERR),
        .OVF(OVF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [15:0] p);
        port_id = p;
        read_strobe = 1;
        @(negedge clk);
        read_strobe = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp, input int bt);
        rx = 0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < (eight ? 8 : 7); i++) begin
            rx = d[i];
            repeat (bt) @(negedge clk);
        end
        if (pen) begin
            rx = par;
            repeat (bt) @(negedge clk);
        end
        rx = stp;
        repeat (bt) @(negedge clk);
        rx = 1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rxrdy", RXRDY, 0);
        check("rst_status", status, 8'h00);
        check("rst_data", data, 8'h00);
        rst = 1;
        repeat (4) @(negedge clk);
        // reset in the middle of a frame, with a word already queued
        send(8'h11, 0, 1, BT);
        check("t1_pre_data", data, 8'h11);
        rx = 0;
        repeat (BT) @(negedge clk);
        rx = 1;
        repeat (BT / 2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check("t1_rst_rxrdy", RXRDY, 0);
        check("t1_rst_ovf", OVF, 0);
        check("t1_rst_status", status, 8'h00);
        rst = 1;
        repeat (12 * BT) @(negedge clk);
        check("t1_idle_rxrdy", RXRDY, 0);
        send(8'h5A, 0, 1, BT);
        check("t1_clean_data", data, 8'h5A);
        check("t1_clean_status", status, 8'h01);
        rd(16'h0000);
        // 8N1 at 115200: push lands 9.5 bit times plus pipeline after the start edge
        baud = 4'd8;
        n = 0;
        fork
            send(8'hA5, 0, 1, BT8);
            while (!RXRDY && n < 9000) begin
                @(negedge clk);
                n++;
            end
        join
        baud = 4'd11;
        check("t2_latency_ok", (n >= 8262 && n <= 8270), 1);
        check("t2_data", data, 8'hA5);
        check("t2_status", status, 8'h01);
        rd(16'h0000);
        check("t2_pop_rxrdy", RXRDY, 0);
        // 7 data bits, even parity
        eight = 0;
        pen = 1;
        even = 1;
        send(8'h35, 1, 1, BT);
        check("t3_bad_data", data, 8'h35);
        check("t3_bad_perr", PERR, 1);
        check("t3_bad_status", status, 8'h03);
        rd(16'h0000);
        send(8'h35, 0, 1, BT);
        check("t3_good_data", data, 8'h35);
        check("t3_good_status", status, 8'h01);
        rd(16'h0000);
        eight = 1;
        even = 0;
        send(8'hA5, 1, 1, BT);
        check("t3_odd_data", data, 8'hA5);
        check("t3_odd_status", status, 8'h01);
        rd(16'h0000);
        pen = 0;
        even = 1;
        // glitch of four oversample ticks
        rx = 0;
        repeat (4 * 7) @(negedge clk);
        rx = 1;
        repeat (3 * BT) @(negedge clk);
        check("t4_false_start", RXRDY, 0);
        // framing error, then a break held for three frame times
        send(8'h3C, 0, 0, BT);
        repeat (BT) @(negedge clk);
        check("t5_ferr_data", data, 8'h3C);
        check("t5_ferr_status", status, 8'h05);
        rd(16'h0000);
        rx = 0;
        repeat (30 * BT) @(negedge clk);
        rx = 1;
        repeat (2 * BT) @(negedge clk);
        check("t5_break_data", data, 8'h00);
        check("t5_break_status", status, 8'h05);
        rd(16'h0000);
        check("t5_break_once", RXRDY, 0);
        // overflow on a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send(8'(i), 0, 1, BT);
        repeat (BT) @(negedge clk);
        check("t6_ovf_status", status, 8'h19);
        for (int i = 1; i <= 4; i++) begin
            check("t6_read_data", data, 16'(i));
            rd(16'h0000);
        end
        check("t6_drained", RXRDY, 0);
        check("t6_ovf_sticky", status, 8'h08);
        rd(16'h0001);
        check("t6_ovf_cleared", status, 8'h00);
        for (int i = 1; i <= 4; i++) send(8'h10 + 8'(i), 0, 1, BT);
        check("t6_refill_status", status, 8'h11);
        // pop timed to the push clock of the fifth frame
        fork
            send(8'h15, 0, 1, BT);
            begin
                repeat (1074) @(negedge clk);
                port_id = 16'h0000;
                read_strobe = 1;
                @(negedge clk);
                read_strobe = 0;
            end
        join
        repeat (BT) @(negedge clk);
        check("t6_pushpop_status", status, 8'h11);
        check("t6_pushpop_head", data, 8'h12);
        clr = 1;
        @(negedge clk);
        clr = 0;
        @(negedge clk);
        check("t6_clr_rxrdy", RXRDY, 0);
        check("t6_clr_status", status, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
